// File: rtl/npu_quant_pkg.sv
// Shared constants for the XPE output requantisation path: activation codes and default geometry.
package npu_quant_pkg;

    localparam int LANES_DEF = 16;
    localparam int ACC_W_DEF = 32;
    localparam int OUT_W_DEF = 16;
    localparam int SHIFT_W   = 5;

    localparam logic [1:0] ACT_NONE  = 2'd0;
    localparam logic [1:0] ACT_RELU  = 2'd1;
    localparam logic [1:0] ACT_LEAKY = 2'd2;

    localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/xpe_lane_quant.sv
// One lane of requantisation: S1 rounding shift, S2 signed saturate (+flag), S3 activation.
// Latency 3 cycles; stage registers load only on their enable, no backpressure.
module xpe_lane_quant
    import npu_quant_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic [1:0]         i_act_mode,
    input  logic               i_s1_en,
    input  logic               i_s2_en,
    input  logic               i_s3_en,
    input  logic [ACC_W-1:0]   i_acc,
    output logic [OUT_W-1:0]   o_dat,
    output logic               o_sat
);

    localparam logic signed [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0]   acc_ext;
    logic signed [ACC_W:0]   bias;
    logic signed [ACC_W:0]   rnd_d, rnd_q;
    logic signed [OUT_W-1:0] sval_d, sval_q;
    logic                    sat_d, sat_q;
    logic signed [OUT_W-1:0] act_d, act_q;

    // One guard bit so the rounding bias cannot overflow the most positive accumulator.
    always_comb begin
        acc_ext = {i_acc[ACC_W-1], i_acc};
        bias    = '0;
        if (i_shift != '0) begin
            bias = ONE <<< (i_shift - 5'd1);
        end
        rnd_d = (acc_ext + bias) >>> i_shift;
    end

    always_comb begin
        sat_d  = 1'b0;
        sval_d = rnd_q[OUT_W-1:0];
        if (rnd_q > MAX_V) begin
            sval_d = MAX_V[OUT_W-1:0];
            sat_d  = 1'b1;
        end else if (rnd_q < MIN_V) begin
            sval_d = MIN_V[OUT_W-1:0];
            sat_d  = 1'b1;
        end
    end

    always_comb begin
        act_d = sval_q;
        case (i_act_mode)
            ACT_RELU:  if (sval_q[OUT_W-1]) act_d = '0;
            ACT_LEAKY: if (sval_q[OUT_W-1]) act_d = sval_q >>> LEAKY_SHIFT;
            default:   act_d = sval_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rnd_q  <= '0;
            sval_q <= '0;
            sat_q  <= 1'b0;
            act_q  <= '0;
        end else begin
            if (i_s1_en) rnd_q <= rnd_d;
            if (i_s2_en) begin
                sval_q <= sval_d;
                sat_q  <= sat_d;
            end
            if (i_s3_en) act_q <= act_d;
        end
    end

    assign o_dat = act_q;
    assign o_sat = sat_q;

endmodule

// File: rtl/xpe_out_quant.sv
// Requantises LANES accumulators per beat into one packed output word for the OAGU, with sat/beat counters.
// Latency 3 cycles, one beat per cycle; no backpressure, a start pulse flushes the pipe.
module xpe_out_quant
    import npu_quant_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_calculate_enable,
    input  logic [SHIFT_W-1:0]     i_shift,
    input  logic [1:0]             i_act_mode,
    input  logic [LANES*ACC_W-1:0] i_acc_dat,
    input  logic                   i_acc_vld,
    output logic [LANES*OUT_W-1:0] o_xpe_dat_out,
    output logic                   o_xpe_dat_vld,
    output logic [15:0]            o_sat_cnt,
    output logic [15:0]            o_beat_cnt
);

    logic [SHIFT_W-1:0] shift_q;
    logic [1:0]         act_q;
    logic               s1_vld_d, s1_vld_q;
    logic               s2_vld_d, s2_vld_q;
    logic               s3_vld_d, s3_vld_q;
    logic [LANES-1:0]   lane_sat;
    logic               beat_sat;
    logic [15:0]        sat_cnt_d, sat_cnt_q;
    logic [15:0]        beat_cnt_d, beat_cnt_q;

    // Start kills every stage, including the beat presented alongside it.
    always_comb begin
        s1_vld_d = i_acc_vld & ~i_calculate_enable;
        s2_vld_d = s1_vld_q  & ~i_calculate_enable;
        s3_vld_d = s2_vld_q  & ~i_calculate_enable;
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        xpe_lane_quant #(
            .ACC_W (ACC_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_shift    (shift_q),
            .i_act_mode (act_q),
            .i_s1_en    (s1_vld_d),
            .i_s2_en    (s2_vld_d),
            .i_s3_en    (s3_vld_d),
            .i_acc      (i_acc_dat[k*ACC_W +: ACC_W]),
            .o_dat      (o_xpe_dat_out[k*OUT_W +: OUT_W]),
            .o_sat      (lane_sat[k])
        );
    end

    assign beat_sat = |lane_sat;

    // Counters advance with the beat entering the output register so they track o_xpe_dat_vld.
    always_comb begin
        sat_cnt_d  = sat_cnt_q;
        beat_cnt_d = beat_cnt_q;
        if (i_calculate_enable) begin
            sat_cnt_d  = '0;
            beat_cnt_d = '0;
        end else if (s3_vld_d) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
            if (beat_sat && (sat_cnt_q != 16'hFFFF)) begin
                sat_cnt_d = sat_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shift_q    <= '0;
            act_q      <= '0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            sat_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (i_calculate_enable) begin
                shift_q <= i_shift;
                act_q   <= i_act_mode;
            end
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            s3_vld_q   <= s3_vld_d;
            sat_cnt_q  <= sat_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign o_xpe_dat_vld = s3_vld_q;
    assign o_sat_cnt     = sat_cnt_q;
    assign o_beat_cnt    = beat_cnt_q;

endmodule

// File: tb/tb_xpe_out_quant.sv
// Bench for xpe_out_quant: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_xpe_out_quant;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_calculate_enable;
    logic [4:0]   i_shift;
    logic [1:0]   i_act_mode;
    logic [511:0] i_acc_dat;
    logic         i_acc_vld;
    logic [255:0] o_xpe_dat_out;
    logic         o_xpe_dat_vld;
    logic [15:0]  o_sat_cnt;
    logic [15:0]  o_beat_cnt;

    xpe_out_quant dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_calculate_enable (i_calculate_enable),
        .i_shift            (i_shift),
        .i_act_mode         (i_act_mode),
        .i_acc_dat          (i_acc_dat),
        .i_acc_vld          (i_acc_vld),
        .o_xpe_dat_out      (o_xpe_dat_out),
        .o_xpe_dat_vld      (o_xpe_dat_vld),
        .o_sat_cnt          (o_sat_cnt),
        .o_beat_cnt         (o_beat_cnt)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int           due;
        logic [255:0] w;
        bit           sat;
    } exp_t;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    exp_t         q[$];
    int           m_shift = 0;
    int           m_act = 0;
    logic [15:0]  m_beat = 16'd0;
    logic [15:0]  m_sat = 16'd0;
    bit           e_vld = 1'b0;
    logic [255:0] e_w = '0;

    function automatic longint floor_div(input longint a, input longint b);
        longint r;
        r = a / b;
        if ((a % b != 0) && (a < 0)) r = r - 1;
        return r;
    endfunction

    // Expected output word: round half up by 2^sh, clamp to int16, then activation.
    function automatic void model_beat(input logic [511:0] d, input int sh, input int act,
                                       output logic [255:0] w, output bit sat);
        longint x, y, dv;
        int     xi;
        w   = '0;
        sat = 1'b0;
        for (int k = 0; k < 16; k++) begin
            xi = d[k*32 +: 32];
            x  = xi;
            if (sh == 0) begin
                y = x;
            end else begin
                dv = longint'(1) << sh;
                y  = floor_div(x + dv / 2, dv);
            end
            if (y > 32767) begin
                y = 32767; sat = 1'b1;
            end else if (y < -32768) begin
                y = -32768; sat = 1'b1;
            end
            if (act == 1 && y < 0) y = 0;
            else if (act == 2 && y < 0) y = floor_div(y, 8);
            w[k*16 +: 16] = y[15:0];
        end
    endfunction

    function automatic logic [511:0] one_lane(input int k, input logic [31:0] v);
        logic [511:0] d;
        d = '0;
        d[k*32 +: 32] = v;
        return d;
    endfunction

    function automatic logic [31:0] rand_acc();
        int t;
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 4000)) - 32'd2000;
            2: begin t = $urandom; return t >>> $urandom_range(8, 20); end
            default: return 32'($urandom_range(0, 80000)) - 32'd40000;
        endcase
    endfunction

    function automatic logic [511:0] rand_beat();
        logic [511:0] d;
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = rand_acc();
        return d;
    endfunction

    // Drive one cycle and advance the reference model to the same point.
    task automatic tick(input bit st, input logic [4:0] sh, input logic [1:0] act,
                        input bit v, input logic [511:0] d);
        exp_t e;
        i_calculate_enable = st;
        i_shift            = sh;
        i_act_mode         = act;
        i_acc_vld          = v;
        i_acc_dat          = d;
        if (st) begin
            q.delete();
            m_shift = int'(sh);
            m_act   = int'(act);
            m_beat  = 16'd0;
            m_sat   = 16'd0;
        end else if (v) begin
            model_beat(d, m_shift, m_act, e.w, e.sat);
            e.due = cyc + 3;
            q.push_back(e);
        end
        @(posedge i_clk);
        #1;
        cyc++;
        e_vld = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            e     = q.pop_front();
            e_vld = 1'b1;
            e_w   = e.w;
            m_beat = m_beat + 16'd1;
            if (e.sat && m_sat != 16'hFFFF) m_sat = m_sat + 16'd1;
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_calculate_enable = 1'b0;
        i_shift = '0;
        i_act_mode = '0;
        i_acc_vld = 1'b0;
        i_acc_dat = '0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", o_xpe_dat_vld); end
        checks++; if (o_xpe_dat_out !== '0) begin errors++; $display("FAIL reset_dat: got %h want 0", o_xpe_dat_out); end
        checks++; if (o_sat_cnt !== 16'd0) begin errors++; $display("FAIL reset_sat: got %h want 0", o_sat_cnt); end
        checks++; if (o_beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_beat: got %h want 0", o_beat_cnt); end
        i_rst = 1'b0;
    endtask

    task automatic test_round();
        tick(1, 5'd4, 2'd0, 0, '0);
        tick(0, 5'd4, 2'd0, 1, one_lane(0, 32'h00000018));
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL round_lat1: vld got %b want 0", o_xpe_dat_vld); end
        tick(0, 5'd4, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL round_lat2: vld got %b want 0", o_xpe_dat_vld); end
        tick(0, 5'd4, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_vld !== 1'b1) begin errors++; $display("FAIL round_vld: got %b want 1", o_xpe_dat_vld); end
        checks++; if (o_xpe_dat_out[15:0] !== 16'h0002) begin errors++; $display("FAIL round_lane0: got %h want 0002", o_xpe_dat_out[15:0]); end
        checks++; if (o_beat_cnt !== 16'd1) begin errors++; $display("FAIL round_beat: got %0d want 1", o_beat_cnt); end
        tick(0, 5'd4, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL round_single: vld got %b want 0", o_xpe_dat_vld); end
    endtask

    task automatic test_saturate();
        tick(1, 5'd0, 2'd0, 0, '0);
        tick(0, 5'd0, 2'd0, 1, one_lane(3, 32'h00012345));
        tick(0, 5'd0, 2'd0, 1, one_lane(3, 32'hFFFE0000));
        tick(0, 5'd0, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_out[63:48] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h want 7fff", o_xpe_dat_out[63:48]); end
        checks++; if (o_sat_cnt !== 16'd1) begin errors++; $display("FAIL sat_cnt1: got %0d want 1", o_sat_cnt); end
        tick(0, 5'd0, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_out[63:48] !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h want 8000", o_xpe_dat_out[63:48]); end
        checks++; if (o_sat_cnt !== 16'd2) begin errors++; $display("FAIL sat_cnt2: got %0d want 2", o_sat_cnt); end
        checks++; if (o_beat_cnt !== 16'd2) begin errors++; $display("FAIL sat_beat: got %0d want 2", o_beat_cnt); end
    endtask

    task automatic test_activation();
        logic [511:0] d;
        // ReLU: -5 -> 0, 7 -> 7
        d = one_lane(0, 32'hFFFFFFFB); d[63:32] = 32'd7;
        tick(1, 5'd0, 2'd1, 0, '0);
        tick(0, 5'd0, 2'd1, 1, d);
        tick(0, 5'd0, 2'd1, 0, '0);
        tick(0, 5'd0, 2'd1, 0, '0);
        checks++; if (o_xpe_dat_out[31:0] !== 32'h0007_0000) begin errors++; $display("FAIL act_relu: got %h want 00070000", o_xpe_dat_out[31:0]); end
        // Leaky: -16 -> -2, -5 -> -1 (floor), 7 -> 7
        d = one_lane(0, 32'hFFFFFFF0); d[63:32] = 32'd7;
        tick(1, 5'd0, 2'd2, 0, '0);
        tick(0, 5'd0, 2'd2, 1, d);
        d[31:0] = 32'hFFFFFFFB;
        tick(0, 5'd0, 2'd2, 1, d);
        tick(0, 5'd0, 2'd2, 0, '0);
        checks++; if (o_xpe_dat_out[31:0] !== 32'h0007_FFFE) begin errors++; $display("FAIL act_leaky16: got %h want 0007fffe", o_xpe_dat_out[31:0]); end
        tick(0, 5'd0, 2'd2, 0, '0);
        checks++; if (o_xpe_dat_out[31:0] !== 32'h0007_FFFF) begin errors++; $display("FAIL act_leaky5: got %h want 0007ffff", o_xpe_dat_out[31:0]); end
        // Mode 3 behaves as no activation
        tick(1, 5'd0, 2'd3, 0, '0);
        tick(0, 5'd0, 2'd3, 1, d);
        tick(0, 5'd0, 2'd3, 0, '0);
        tick(0, 5'd0, 2'd3, 0, '0);
        checks++; if (o_xpe_dat_out[31:0] !== 32'h0007_FFFB) begin errors++; $display("FAIL act_mode3: got %h want 0007fffb", o_xpe_dat_out[31:0]); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] sh;
        logic [1:0] act;
        bit         v;
        int         pulses;
        sh = 5'($urandom_range(0, 12));
        act = 2'($urandom_range(0, 3));
        pulses = 0;
        tick(1, sh, act, 0, '0);
        for (int i = 0; i < 14; i++) begin
            v = (i < 10) && (i != 3) && (i != 6);
            tick(0, sh, act, v, v ? rand_beat() : '0);
            checks++; if (o_xpe_dat_vld !== e_vld) begin errors++; $display("FAIL b2b_vld[%0d]: got %b want %b", i, o_xpe_dat_vld, e_vld); end
            if (e_vld) begin
                pulses++;
                checks++; if (o_xpe_dat_out !== e_w) begin errors++; $display("FAIL b2b_dat[%0d]: got %h want %h", i, o_xpe_dat_out, e_w); end
            end
        end
        checks++; if (pulses != 8) begin errors++; $display("FAIL b2b_pulses: got %0d want 8", pulses); end
        checks++; if (o_beat_cnt !== 16'd8) begin errors++; $display("FAIL b2b_beat: got %0d want 8", o_beat_cnt); end
    endtask

    task automatic test_start_flush();
        tick(1, 5'd1, 2'd0, 0, '0);
        tick(0, 5'd1, 2'd0, 1, rand_beat());
        tick(0, 5'd1, 2'd0, 1, rand_beat());
        tick(1, 5'd3, 2'd0, 1, rand_beat());
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL flush_vld0: got %b want 0", o_xpe_dat_vld); end
        checks++; if (o_beat_cnt !== 16'd0) begin errors++; $display("FAIL flush_beat: got %0d want 0", o_beat_cnt); end
        checks++; if (o_sat_cnt !== 16'd0) begin errors++; $display("FAIL flush_sat: got %0d want 0", o_sat_cnt); end
        tick(0, 5'd3, 2'd0, 1, one_lane(0, 32'h00000018));
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL flush_vld1: got %b want 0", o_xpe_dat_vld); end
        tick(0, 5'd3, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL flush_vld2: got %b want 0", o_xpe_dat_vld); end
        tick(0, 5'd3, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_vld !== 1'b1) begin errors++; $display("FAIL flush_newvld: got %b want 1", o_xpe_dat_vld); end
        checks++; if (o_xpe_dat_out[15:0] !== 16'h0003) begin errors++; $display("FAIL flush_newshift: got %h want 0003", o_xpe_dat_out[15:0]); end
        checks++; if (o_beat_cnt !== 16'd1) begin errors++; $display("FAIL flush_newbeat: got %0d want 1", o_beat_cnt); end
    endtask

    task automatic test_sat_sticky_and_reset();
        logic [511:0] d;
        d = one_lane(0, 32'h7FFFFFFF);
        tick(1, 5'd0, 2'd0, 0, '0);
        for (int i = 0; i < 65534; i++) tick(0, 5'd0, 2'd0, 1, d);
        tick(0, 5'd0, 2'd0, 0, '0);
        tick(0, 5'd0, 2'd0, 0, '0);
        checks++; if (o_sat_cnt !== 16'hFFFE) begin errors++; $display("FAIL sticky_pre: got %h want fffe", o_sat_cnt); end
        checks++; if (o_beat_cnt !== 16'hFFFE) begin errors++; $display("FAIL sticky_beatpre: got %h want fffe", o_beat_cnt); end
        for (int i = 0; i < 3; i++) tick(0, 5'd0, 2'd0, 1, d);
        tick(0, 5'd0, 2'd0, 0, '0);
        tick(0, 5'd0, 2'd0, 0, '0);
        checks++; if (o_sat_cnt !== 16'hFFFF) begin errors++; $display("FAIL sticky_hold: got %h want ffff", o_sat_cnt); end
        checks++; if (o_beat_cnt !== 16'd1) begin errors++; $display("FAIL beat_wrap: got %h want 0001", o_beat_cnt); end
        checks++; if (o_xpe_dat_out[15:0] !== 16'h7FFF) begin errors++; $display("FAIL sticky_dat: got %h want 7fff", o_xpe_dat_out[15:0]); end
        // Asynchronous reset with beats in flight
        tick(0, 5'd0, 2'd0, 1, d);
        tick(0, 5'd0, 2'd0, 1, d);
        #2;
        i_rst = 1'b1;
        #1;
        checks++; if (o_xpe_dat_vld !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b want 0", o_xpe_dat_vld); end
        checks++; if (o_xpe_dat_out !== '0) begin errors++; $display("FAIL arst_dat: got %h want 0", o_xpe_dat_out); end
        checks++; if (o_sat_cnt !== 16'd0) begin errors++; $display("FAIL arst_sat: got %h want 0", o_sat_cnt); end
        checks++; if (o_beat_cnt !== 16'd0) begin errors++; $display("FAIL arst_beat: got %h want 0", o_beat_cnt); end
        q.delete();
        m_shift = 0; m_act = 0; m_beat = 16'd0; m_sat = 16'd0;
        i_acc_vld = 1'b0;
        @(posedge i_clk);
        #1;
        cyc++;
        i_rst = 1'b0;
        tick(0, 5'd0, 2'd0, 1, one_lane(0, 32'd5));
        tick(0, 5'd0, 2'd0, 0, '0);
        tick(0, 5'd0, 2'd0, 0, '0);
        checks++; if (o_xpe_dat_vld !== 1'b1) begin errors++; $display("FAIL post_rst_vld: got %b want 1", o_xpe_dat_vld); end
        checks++; if (o_xpe_dat_out[15:0] !== 16'd5) begin errors++; $display("FAIL post_rst_dat: got %h want 0005", o_xpe_dat_out[15:0]); end
        checks++; if (o_beat_cnt !== 16'd1) begin errors++; $display("FAIL post_rst_beat: got %0d want 1", o_beat_cnt); end
    endtask

    task automatic test_random();
        logic [4:0] sh;
        logic [1:0] act;
        bit         st, v;
        sh = 5'($urandom_range(0, 31));
        act = 2'($urandom_range(0, 3));
        tick(1, sh, act, 0, '0);
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 39) == 0);
            if (st) begin
                sh = 5'($urandom_range(0, 31));
                act = 2'($urandom_range(0, 3));
            end
            v = ($urandom_range(0, 3) != 0);
            tick(st, sh, act, v, rand_beat());
            checks++; if (o_xpe_dat_vld !== e_vld) begin errors++; $display("FAIL rnd_vld[%0d]: got %b want %b", i, o_xpe_dat_vld, e_vld); end
            if (e_vld) begin
                checks++; if (o_xpe_dat_out !== e_w) begin errors++; $display("FAIL rnd_dat[%0d]: got %h want %h", i, o_xpe_dat_out, e_w); end
            end
            checks++; if (o_beat_cnt !== m_beat) begin errors++; $display("FAIL rnd_beat[%0d]: got %0d want %0d", i, o_beat_cnt, m_beat); end
            checks++; if (o_sat_cnt !== m_sat) begin errors++; $display("FAIL rnd_sat[%0d]: got %0d want %0d", i, o_sat_cnt, m_sat); end
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_saturate();
        test_activation();
        test_back_to_back();
        test_start_flush();
        test_random();
        test_sat_sticky_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
